// File: rtl/core_pkg.sv
// Shared core types: memory-arbiter state and grant encodings, plus a counter-width helper.
package core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RESP = 2'd2
    } ArbState;

    typedef enum logic [1:0] {
        GNT_IF     = 2'd0,
        GNT_LSU_RD = 2'd1,
        GNT_LSU_WR = 2'd2
    } ArbGrant;

    // Bits needed to count 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// Bus timeout counter: cleared at transaction start, counts enabled bus cycles,
// flags expiry once the count reaches TIMEOUT.
module bus_timeout
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire_c
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    logic [CW-1:0] r_count;

    assign o_expire_c = (r_count == CW'(TIMEOUT));

    // Saturates at TIMEOUT so a stalled response cannot wrap the count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_expire_c) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory bus arbiter: grants fetch or LSU access to the single memory bus,
// tracks the transaction to ack or timeout, and returns a one-cycle response.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned MAX_LSU_BURST = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clk_en,
    input  logic            i_if_read,
    input  logic [AW-1:0]   i_if_addr,
    output logic [DW-1:0]   o_if_data,
    output logic            o_if_ack,
    output logic            o_if_err,
    input  logic            i_lsu_read,
    input  logic [AW-1:0]   i_r_lsu_addr,
    output logic [DW-1:0]   o_r_lsu_data,
    input  logic            i_lsu_write,
    input  logic [AW-1:0]   i_w_lsu_addr,
    input  logic [DW/8-1:0] i_w_lsu_byte_en,
    input  logic [DW-1:0]   i_w_lsu_data,
    output logic            o_lsu_ack,
    output logic            o_lsu_err,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW/8-1:0] o_mem_byte_en,
    output logic [DW-1:0]   o_mem_wdata,
    input  logic [DW-1:0]   i_mem_rdata,
    input  logic            i_mem_ack,
    output logic            o_busy
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned SW = cnt_width(MAX_LSU_BURST);

    ArbState        r_state;
    ArbGrant        r_grant;
    logic [SW-1:0]  r_streak;
    logic           r_ack_pend;
    logic [DW-1:0]  r_pend_data;
    logic           r_mem_req;
    logic           r_mem_we;
    logic [AW-1:0]  r_mem_addr;
    logic [BW-1:0]  r_mem_be;
    logic [DW-1:0]  r_mem_wdata;
    logic           r_if_ack;
    logic           r_if_err;
    logic [DW-1:0]  r_if_data;
    logic           r_lsu_ack;
    logic           r_lsu_err;
    logic [DW-1:0]  r_lsu_data;
    logic           r_busy;

    logic           w_any_req;
    logic           w_starve;
    ArbGrant        w_winner;
    logic           w_ack;
    logic [DW-1:0]  w_ack_data;
    logic           w_tmo_clr;
    logic           w_tmo_inc;
    logic           w_expire;

    // Winner selection; a pending ack captured while stalled takes precedence over the live bus.
    always_comb begin
        w_any_req  = i_if_read | i_lsu_read | i_lsu_write;
        w_starve   = i_if_read && (r_streak == SW'(MAX_LSU_BURST));
        w_winner   = GNT_IF;
        if (!w_starve && i_lsu_write) begin
            w_winner = GNT_LSU_WR;
        end else if (!w_starve && i_lsu_read) begin
            w_winner = GNT_LSU_RD;
        end
        w_ack      = r_ack_pend | i_mem_ack;
        w_ack_data = r_ack_pend ? r_pend_data : i_mem_rdata;
        w_tmo_clr  = i_clk_en && (r_state == ARB_IDLE) && w_any_req;
        w_tmo_inc  = i_clk_en && (r_state == ARB_BUS);
    end

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timeout (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_tmo_clr),
        .i_inc      (w_tmo_inc),
        .o_expire_c (w_expire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ARB_IDLE;
            r_grant     <= GNT_IF;
            r_streak    <= '0;
            r_ack_pend  <= 1'b0;
            r_pend_data <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_data   <= '0;
            r_lsu_ack   <= 1'b0;
            r_lsu_err   <= 1'b0;
            r_lsu_data  <= '0;
            r_busy      <= 1'b0;
        end else if (!i_clk_en) begin
            // Everything holds; only a bus ack is remembered for the next enabled cycle.
            if ((r_state == ARB_BUS) && i_mem_ack && !r_ack_pend) begin
                r_ack_pend  <= 1'b1;
                r_pend_data <= i_mem_rdata;
            end
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= ARB_BUS;
                        r_busy    <= 1'b1;
                        r_mem_req <= 1'b1;
                        r_grant   <= w_winner;
                        case (w_winner)
                            GNT_LSU_WR: begin
                                r_mem_addr  <= i_w_lsu_addr;
                                r_mem_we    <= 1'b1;
                                r_mem_be    <= i_w_lsu_byte_en;
                                r_mem_wdata <= i_w_lsu_data;
                            end
                            GNT_LSU_RD: begin
                                r_mem_addr  <= i_r_lsu_addr;
                                r_mem_we    <= 1'b0;
                                r_mem_be    <= '1;
                                r_mem_wdata <= '0;
                            end
                            default: begin
                                r_mem_addr  <= i_if_addr;
                                r_mem_we    <= 1'b0;
                                r_mem_be    <= '1;
                                r_mem_wdata <= '0;
                            end
                        endcase
                        if (w_winner == GNT_IF) begin
                            r_streak <= '0;
                        end else if (r_streak != SW'(MAX_LSU_BURST)) begin
                            r_streak <= r_streak + SW'(1);
                        end
                    end
                end
                ARB_BUS: begin
                    if (w_ack || w_expire) begin
                        r_state    <= ARB_RESP;
                        r_mem_req  <= 1'b0;
                        r_ack_pend <= 1'b0;
                        if (r_grant == GNT_IF) begin
                            r_if_ack  <= 1'b1;
                            r_if_err  <= !w_ack;
                            r_if_data <= w_ack ? w_ack_data : '0;
                        end else begin
                            r_lsu_ack  <= 1'b1;
                            r_lsu_err  <= !w_ack;
                            r_lsu_data <= w_ack ? w_ack_data : '0;
                        end
                    end
                end
                ARB_RESP: begin
                    r_state   <= ARB_IDLE;
                    r_busy    <= 1'b0;
                    r_if_ack  <= 1'b0;
                    r_if_err  <= 1'b0;
                    r_lsu_ack <= 1'b0;
                    r_lsu_err <= 1'b0;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_if_data     = r_if_data;
    assign o_if_ack      = r_if_ack;
    assign o_if_err      = r_if_err;
    assign o_r_lsu_data  = r_lsu_data;
    assign o_lsu_ack     = r_lsu_ack;
    assign o_lsu_err     = r_lsu_err;
    assign o_mem_req     = r_mem_req;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_byte_en = r_mem_be;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned BW      = DW / 8;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned MAXB    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          if_read = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          lsu_read = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic          lsu_write = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [BW-1:0] w_be = '0;
    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    logic [DW-1:0] o_if_data;
    logic          o_if_ack;
    logic          o_if_err;
    logic [DW-1:0] o_r_lsu_data;
    logic          o_lsu_ack;
    logic          o_lsu_err;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [BW-1:0] o_mem_byte_en;
    logic [DW-1:0] o_mem_wdata;
    logic          o_busy;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW            (AW),
        .DW            (DW),
        .TIMEOUT       (TIMEOUT),
        .MAX_LSU_BURST (MAXB)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_clk_en        (clk_en),
        .i_if_read       (if_read),
        .i_if_addr       (if_addr),
        .o_if_data       (o_if_data),
        .o_if_ack        (o_if_ack),
        .o_if_err        (o_if_err),
        .i_lsu_read      (lsu_read),
        .i_r_lsu_addr    (r_addr),
        .o_r_lsu_data    (o_r_lsu_data),
        .i_lsu_write     (lsu_write),
        .i_w_lsu_addr    (w_addr),
        .i_w_lsu_byte_en (w_be),
        .i_w_lsu_data    (w_data),
        .o_lsu_ack       (o_lsu_ack),
        .o_lsu_err       (o_lsu_err),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_byte_en   (o_mem_byte_en),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_rdata     (mem_rdata),
        .i_mem_ack       (mem_ack),
        .o_busy          (o_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, its age in enabled bus cycles,
    // and the response it owes. Requester ids: 0 fetch, 1 LSU read, 2 LSU write.
    bit            m_bus = 0;
    bit            m_resp = 0;
    bit            m_pend = 0;
    int            m_age = 0;
    int            m_streak = 0;
    int            m_who = 0;
    logic [DW-1:0] m_pdata = '0;
    logic [AW-1:0] e_addr = '0;
    logic          e_we = 1'b0;
    logic [BW-1:0] e_be = '0;
    logic [DW-1:0] e_wd = '0;
    logic          e_if_ack = 1'b0;
    logic          e_if_err = 1'b0;
    logic [DW-1:0] e_if_data = '0;
    logic          e_lsu_ack = 1'b0;
    logic          e_lsu_err = 1'b0;
    logic [DW-1:0] e_lsu_data = '0;
    int            glog[$];

    task automatic model_complete(input logic [DW-1:0] d, input bit err);
        m_bus  = 0;
        m_resp = 1;
        m_pend = 0;
        if (m_who == 0) begin
            e_if_ack = 1'b1; e_if_err = err; e_if_data = d;
        end else begin
            e_lsu_ack = 1'b1; e_lsu_err = err; e_lsu_data = d;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_bus = 0; m_resp = 0; m_pend = 0; m_age = 0; m_streak = 0;
            e_if_ack = 1'b0; e_if_err = 1'b0; e_lsu_ack = 1'b0; e_lsu_err = 1'b0;
        end else if (!clk_en) begin
            if (m_bus && mem_ack && !m_pend) begin
                m_pend  = 1;
                m_pdata = mem_rdata;
            end
        end else if (m_resp) begin
            m_resp = 0;
            e_if_ack = 1'b0; e_if_err = 1'b0; e_lsu_ack = 1'b0; e_lsu_err = 1'b0;
        end else if (m_bus) begin
            if (m_pend)                model_complete(m_pdata, 0);
            else if (mem_ack)          model_complete(mem_rdata, 0);
            else if (m_age == TIMEOUT) model_complete('0, 1);
            else                       m_age++;
        end else if (if_read || lsu_read || lsu_write) begin
            if (if_read && m_streak >= MAXB) m_who = 0;
            else if (lsu_write)              m_who = 2;
            else if (lsu_read)               m_who = 1;
            else                             m_who = 0;
            m_streak = (m_who == 0) ? 0 : ((m_streak < MAXB) ? m_streak + 1 : MAXB);
            glog.push_back(m_who);
            m_bus  = 1;
            m_age  = 0;
            e_addr = (m_who == 0) ? if_addr : ((m_who == 1) ? r_addr : w_addr);
            e_we   = (m_who == 2);
            e_be   = (m_who == 2) ? w_be : '1;
            e_wd   = w_data;
        end
    end

    task automatic check_outputs();
        chk("busy", 64'(o_busy), 64'(m_bus || m_resp));
        chk("mem_req", 64'(o_mem_req), 64'(m_bus));
        if (m_bus) begin
            chk("mem_addr", 64'(o_mem_addr), 64'(e_addr));
            chk("mem_we", 64'(o_mem_we), 64'(e_we));
            chk("mem_be", 64'(o_mem_byte_en), 64'(e_be));
            if (e_we) chk("mem_wdata", 64'(o_mem_wdata), 64'(e_wd));
        end
        chk("if_ack", 64'(o_if_ack), 64'(e_if_ack));
        chk("lsu_ack", 64'(o_lsu_ack), 64'(e_lsu_ack));
        if (e_if_ack) begin
            chk("if_err", 64'(o_if_err), 64'(e_if_err));
            chk("if_data", 64'(o_if_data), 64'(e_if_data));
        end
        if (e_lsu_ack) begin
            chk("lsu_err", 64'(o_lsu_err), 64'(e_lsu_err));
            chk("lsu_data", 64'(o_r_lsu_data), 64'(e_lsu_data));
        end
    endtask

    // Memory responder modes: 0 random, 1 ack at once with mem_data, 2 never, 3 driven by caller.
    int            mem_mode = 3;
    logic [DW-1:0] mem_data = '0;
    logic          prev_req = 1'b0;
    logic [AW-1:0] dlog[$];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        if (o_mem_req && !prev_req) dlog.push_back(o_mem_addr);
        prev_req = o_mem_req;
        case (mem_mode)
            0: begin
                mem_ack   = o_mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
                mem_rdata = $urandom;
            end
            1: begin
                mem_ack   = o_mem_req;
                mem_rdata = mem_data;
            end
            2: mem_ack = 1'b0;
            default: ;
        endcase
    endtask

    int            req_cnt;
    bit            got;
    logic          t_err;
    logic [DW-1:0] t_data;
    logic [AW-1:0] st_exp_addr[6];
    int            st_exp_who[6];

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_mem_req", 64'(o_mem_req), 64'(0));
        chk("rst_mem_be", 64'(o_mem_byte_en), 64'(0));
        chk("rst_mem_addr", 64'(o_mem_addr), 64'(0));
        chk("rst_if_ack", 64'(o_if_ack), 64'(0));
        chk("rst_lsu_ack", 64'(o_lsu_ack), 64'(0));
        rst_n = 1'b1;
        tick();

        // Fetch-only read, zero-wait memory
        mem_mode = 1; mem_data = 32'hDEADBEEF;
        if_read = 1'b1; if_addr = 32'h100;
        tick();
        chk("t1_req", 64'(o_mem_req), 64'(1));
        chk("t1_addr", 64'(o_mem_addr), 64'h100);
        chk("t1_we", 64'(o_mem_we), 64'(0));
        chk("t1_be", 64'(o_mem_byte_en), 64'hF);
        tick();
        chk("t1_ack", 64'(o_if_ack), 64'(1));
        chk("t1_data", 64'(o_if_data), 64'hDEADBEEF);
        chk("t1_err", 64'(o_if_err), 64'(0));
        chk("t1_req_drop", 64'(o_mem_req), 64'(0));
        chk("t1_model_data", 64'(e_if_data), 64'hDEADBEEF);
        if_read = 1'b0;
        tick();
        chk("t1_ack_pulse", 64'(o_if_ack), 64'(0));
        chk("t1_idle", 64'(o_busy), 64'(0));

        // Simultaneous LSU write and fetch: write first
        lsu_write = 1'b1; w_addr = 32'h200; w_be = 4'b0011; w_data = 32'h1234;
        if_read = 1'b1; if_addr = 32'h104;
        tick();
        chk("t2_we", 64'(o_mem_we), 64'(1));
        chk("t2_be", 64'(o_mem_byte_en), 64'h3);
        chk("t2_addr", 64'(o_mem_addr), 64'h200);
        chk("t2_wdata", 64'(o_mem_wdata), 64'h1234);
        tick();
        chk("t2_lsu_ack", 64'(o_lsu_ack), 64'(1));
        chk("t2_lsu_err", 64'(o_lsu_err), 64'(0));
        chk("t2_if_ack", 64'(o_if_ack), 64'(0));
        lsu_write = 1'b0;
        tick();
        chk("t2_gap_idle", 64'(o_busy), 64'(0));
        tick();
        chk("t2_fetch_req", 64'(o_mem_req), 64'(1));
        chk("t2_fetch_addr", 64'(o_mem_addr), 64'h104);
        tick();
        chk("t2_fetch_ack", 64'(o_if_ack), 64'(1));
        if_read = 1'b0;
        tick();

        // Starvation override: 4 LSU reads, 1 fetch, LSU resumes
        dlog.delete(); glog.delete();
        mem_data = 32'h0BADF00D;
        lsu_read = 1'b1; r_addr = 32'h300;
        if_read = 1'b1; if_addr = 32'h400;
        for (int c = 0; c < 18; c++) begin
            tick();
            if (o_if_ack) if_read = 1'b0;
        end
        lsu_read = 1'b0;
        tick(); tick();
        st_exp_addr = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h400, 32'h300};
        st_exp_who  = '{1, 1, 1, 1, 0, 1};
        chk("st_dut_grants", 64'(dlog.size()), 64'(6));
        chk("st_model_grants", 64'(glog.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < dlog.size()) chk($sformatf("st_dut_grant%0d", i), 64'(dlog[i]), 64'(st_exp_addr[i]));
            if (i < glog.size()) chk($sformatf("st_model_grant%0d", i), 64'(glog[i]), 64'(st_exp_who[i]));
        end

        // Memory never acks: timeout error response
        mem_mode = 2;
        lsu_read = 1'b1; r_addr = 32'h600;
        req_cnt = 0; got = 0; t_err = 1'b0; t_data = '1;
        for (int c = 0; c < 300 && !got; c++) begin
            tick();
            if (o_mem_req) req_cnt++;
            if (o_lsu_ack) begin
                got = 1; t_err = o_lsu_err; t_data = o_r_lsu_data;
            end
        end
        chk("to_ack_seen", 64'(got), 64'(1));
        chk("to_req_cycles", 64'(req_cnt), 64'(TIMEOUT + 1));
        chk("to_err", 64'(t_err), 64'(1));
        chk("to_data", 64'(t_data), 64'(0));
        lsu_read = 1'b0;
        tick(); tick();

        // Ack arriving while the clock enable is low
        mem_mode = 3;
        if_read = 1'b1; if_addr = 32'h500;
        tick();
        chk("ce_req", 64'(o_mem_req), 64'(1));
        clk_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("ce_frozen_req", 64'(o_mem_req), 64'(1));
        chk("ce_no_ack", 64'(o_if_ack), 64'(0));
        mem_ack = 1'b0; mem_rdata = 32'h11111111;
        tick();
        chk("ce_still_frozen", 64'(o_if_ack), 64'(0));
        chk("ce_busy", 64'(o_busy), 64'(1));
        clk_en = 1'b1;
        tick();
        chk("ce_ack", 64'(o_if_ack), 64'(1));
        chk("ce_data", 64'(o_if_data), 64'hCAFEF00D);
        chk("ce_err", 64'(o_if_err), 64'(0));
        if_read = 1'b0; clk_en = 1'b0;
        tick();
        chk("ce_ack_hold", 64'(o_if_ack), 64'(1));
        clk_en = 1'b1;
        tick();
        chk("ce_ack_done", 64'(o_if_ack), 64'(0));
        tick();

        // Reset in the middle of a bus transaction
        mem_mode = 2;
        lsu_write = 1'b1; w_addr = 32'h700; w_be = 4'hF; w_data = 32'h55;
        tick(); tick();
        chk("rs_in_bus", 64'(o_mem_req), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("rs_req", 64'(o_mem_req), 64'(0));
        chk("rs_busy", 64'(o_busy), 64'(0));
        chk("rs_no_ack", 64'(o_lsu_ack), 64'(0));
        rst_n = 1'b1; lsu_write = 1'b0;
        mem_mode = 3; mem_ack = 1'b1; mem_rdata = 32'h77;
        tick();
        chk("rs_late_ack_ignored", 64'(o_lsu_ack), 64'(0));
        chk("rs_late_busy", 64'(o_busy), 64'(0));
        mem_ack = 1'b0;
        tick();
        chk("rs_quiet", 64'(o_lsu_ack), 64'(0));

        // Randomized traffic against the model
        mem_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            clk_en = ($urandom_range(0, 9) != 0);
            rst_n  = ($urandom_range(0, 799) != 0);
            if (!if_read && !o_if_ack && $urandom_range(0, 3) == 0) begin
                if_read = 1'b1; if_addr = $urandom;
            end
            if (!lsu_read && !lsu_write && !o_lsu_ack && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    lsu_write = 1'b1; w_addr = $urandom; w_be = BW'($urandom); w_data = $urandom;
                end else begin
                    lsu_read = 1'b1; r_addr = $urandom;
                end
            end
            tick();
            if (o_if_ack) if_read = 1'b0;
            if (o_lsu_ack) begin
                lsu_read = 1'b0; lsu_write = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the core's single memory bus between the instruction-fetch read port and the LSU read/write ports. The LSU and fetch unit each drive level-held requests. The arbiter grants one requester at a time, registers the transaction onto the bus, waits for the memory ack, and returns a one-cycle ack with data to the winner. A bus-timeout counter converts a missing memory ack into an error response, so the pipeline never hangs.

## Interface
- AW, 32, address width
- DW, 32, data width; byte enables are DW/8 bits
- TIMEOUT, 255, max cycles in BUS without i_mem_ack before error
- MAX_LSU_BURST, 4, consecutive LSU grants allowed while fetch is pending
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  synchronous reset, active-low
- i_clk_en  in  1  advance enable for FSM and counters
- i_if_read  in  1  fetch read request, held until o_if_ack
- i_if_addr  in  AW  fetch address
- o_if_data  out  DW  fetch read data, valid with o_if_ack
- o_if_ack  out  1  one-cycle completion pulse to fetch
- o_if_err  out  1  timeout flag, valid with o_if_ack
- i_lsu_read  in  1  LSU read request, held until o_lsu_ack
- i_r_lsu_addr  in  AW  LSU read address
- o_r_lsu_data  out  DW  LSU read data, valid with o_lsu_ack
- i_lsu_write  in  1  LSU write request, held until o_lsu_ack
- i_w_lsu_addr  in  AW  LSU write address
- i_w_lsu_byte_en  in  DW/8  write byte enables
- i_w_lsu_data  in  DW  write data
- o_lsu_ack  out  1  one-cycle completion pulse for LSU read or write
- o_lsu_err  out  1  timeout flag, valid with o_lsu_ack
- o_mem_req  out  1  bus request, held until ack or timeout
- o_mem_we  out  1  1 = write
- o_mem_addr  out  AW  bus address
- o_mem_byte_en  out  DW/8  bus byte enables; all ones for reads
- o_mem_wdata  out  DW  bus write data
- i_mem_rdata  in  DW  bus read data, valid with i_mem_ack
- i_mem_ack  in  1  one-cycle bus completion
- o_busy  out  1  state != IDLE

## Operation
- States:
  - IDLE → BUS on any request; the winner is latched.
  - BUS → RESP on i_mem_ack or timeout.
  - RESP → IDLE unconditionally.
- Grant priority in IDLE:
  1. LSU write.
  2. LSU read.
  3. Fetch.
- Starvation override: if lsu_streak == MAX_LSU_BURST and i_if_read is high, fetch wins.
- lsu_streak:
  - increments on each LSU grant, saturating;
  - clears on each fetch grant.
- On grant: o_mem_addr/we/byte_en/wdata are registered from the winner and held stable through BUS. Requester inputs are ignored after grant.
- BUS state:
  - o_mem_req = 1.
  - A timeout counter starts at 0 on entry and increments each enabled cycle.
  - At count == TIMEOUT with no ack: drop o_mem_req and enter RESP with error.
- RESP state:
  - Exactly one of o_if_ack/o_lsu_ack = 1.
  - Read data comes from i_mem_rdata captured at the ack; it is 0 on error.
  - err = 1 only on timeout.
  - Requests are ignored during RESP, so the requester can deassert.
- Simultaneous i_mem_ack and count == TIMEOUT: ack wins, err = 0.
- i_mem_ack outside BUS is ignored.
- i_clk_en low:
  - state, counters and outputs hold;
  - an i_mem_ack arriving in BUS is captured into a sticky ack_pend bit with its data, and consumed on the next enabled cycle.
- Reset (any state, including mid-BUS): state IDLE; lsu_streak, timeout count and ack_pend = 0. No ack is issued for an abandoned transaction.

## Timing
- Reset values: all outputs 0 (o_mem_byte_en 0, o_busy 0).
- Request high in IDLE at edge N → o_mem_req = 1 from cycle N+1.
- i_mem_ack at cycle M → requester ack/data in cycle M+1 (RESP) → IDLE at M+2 → next o_mem_req earliest M+3.
- Zero-wait memory (ack in first BUS cycle): 3 cycles per transaction.
- Timeout: o_mem_req is high for TIMEOUT+1 cycles, then the err ack follows in the next cycle.
- Ack outputs are high for exactly one enabled cycle.

## Structure
- Shared package core_pkg:
  - typedef enum ArbState {ARB_IDLE, ARB_BUS, ARB_RESP};
  - typedef enum ArbGrant {GNT_IF, GNT_LSU_RD, GNT_LSU_WR}.
- Sub-module bus_timeout: clear/enable/expire counter parameterised by TIMEOUT. Width is $clog2(TIMEOUT+1).
- Arbiter FSM, grant logic and lsu_streak live in mem_arbiter.

## Test plan
- Fetch-only read of 0x100, memory acks in its 1st BUS cycle with 0xDEADBEEF → o_mem_req 1 cycle, o_if_ack in the next cycle with o_if_data = 0xDEADBEEF, o_if_err = 0.
- i_lsu_write and i_if_read asserted in the same cycle (addr 0x200, byte_en 4'b0011, data 0x1234) → write granted first with o_mem_we = 1 and byte_en = 0011; fetch is granted after the RESP/IDLE cycles.
- LSU read requests held back-to-back with fetch pending throughout, MAX_LSU_BURST = 4 → 4 LSU grants, then 1 fetch grant, then LSU resumes.
- Memory never acks, TIMEOUT = 255 → o_mem_req high 256 cycles, then o_lsu_ack = 1 with o_lsu_err = 1 and data 0.
- i_mem_ack arrives while i_clk_en = 0 → ack_pend set, outputs frozen; on re-enable, o_if_ack pulses with the captured data.
- i_rst_n low during BUS → next cycle o_mem_req = 0, o_busy = 0, no ack pulse; a late i_mem_ack is ignored.
